// File: rtl/ins_fetcher.sv
// Instruction fetcher: one outstanding fetch at a time feeds an in-order queue; the head is presented combinationally.
// Fetch request is withheld while the queue is full, a fetch is outstanding, or a flush is pending; rdy_in low freezes everything.
module ins_fetcher #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush_pipline,
  input  logic [31:0] flush_pc,
  output logic        try_start_insfetch_task,
  output logic [31:0] insfetch_addr,
  input  logic        insfetch_task_done,
  input  logic [31:0] insfetch_ins_full,
  output logic        ins_out_valid,
  output logic [31:0] ins_out_ins,
  output logic [31:0] ins_out_pc,
  output logic        ins_out_is_compressed,
  input  logic        ins_out_ready
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [31:0]     q_ins_q [QUEUE_DEPTH];
  logic [31:0]     q_pc_q  [QUEUE_DEPTH];
  logic            q_c_q   [QUEUE_DEPTH];

  logic            fetch_compressed;
  logic            push;
  logic            pop;
  logic            push_en;

  assign fetch_compressed = (insfetch_ins_full[1:0] != 2'b11);

  // Request is suppressed while in reset so nothing is issued before release.
  assign try_start_insfetch_task = (state_q == IDLE) && (count_q < CW'(QUEUE_DEPTH))
                                   && !flush_pipline && !rst_in;
  assign insfetch_addr = pc_q;

  assign ins_out_valid         = (count_q != '0);
  assign ins_out_ins           = q_ins_q[head_q];
  assign ins_out_pc            = q_pc_q[head_q];
  assign ins_out_is_compressed = q_c_q[head_q];

  assign push    = (state_q == WAIT) && insfetch_task_done;
  assign pop     = ins_out_valid && ins_out_ready;
  assign push_en = rdy_in && !flush_pipline && push;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (flush_pipline) begin
        state_d = IDLE;
        pc_d    = flush_pc;
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (state_q == IDLE) begin
          if (try_start_insfetch_task) state_d = WAIT;
        end else begin
          if (insfetch_task_done) state_d = IDLE;
        end
        if (push) begin
          tail_d = tail_q + 1'b1;
          pc_d   = pc_q + (fetch_compressed ? 32'd2 : 32'd4);
        end
        if (pop) head_d = head_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue payload needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push_en) begin
      q_ins_q[tail_q] <= insfetch_ins_full;
      q_pc_q[tail_q]  <= pc_q;
      q_c_q[tail_q]   <= fetch_compressed;
    end
  end

endmodule

// File: doc/ins_fetcher.md
INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high; ports named clk_in and rst_in.
REQ-002 SHALL expose parameter QUEUE_DEPTH, default 4, meaning the number of instruction-queue entries; fixed power of two, at least 2.
REQ-003 SHALL expose parameter RESET_PC, default 32'h0, meaning the fetch address after reset.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_in  input  1  synchronous active-high reset.
REQ-006 rdy_in  input  1  global ready; low freezes all state.
REQ-007 flush_pipline  input  1  redirect request; discard all queued and in-flight fetches.
REQ-008 flush_pc  input  32  new fetch address, valid with flush_pipline.
REQ-009 try_start_insfetch_task  output  1  fetch request to the memory adapter.
REQ-010 insfetch_addr  output  32  fetch address, valid with try_start_insfetch_task.
REQ-011 insfetch_task_done  input  1  adapter completion pulse.
REQ-012 insfetch_ins_full  input  32  fetched instruction, valid with done; upper 16 bits are zero for compressed instructions.
REQ-013 ins_out_valid  output  1  queue head is valid.
REQ-014 ins_out_ins  output  32  queue head instruction.
REQ-015 ins_out_pc  output  32  queue head address.
REQ-016 ins_out_is_compressed  output  1  queue head is a 16-bit instruction.
REQ-017 ins_out_ready  input  1  consumer accepts the head this cycle.

Function
REQ-018 SHALL use a two-state FSM: IDLE (no fetch outstanding) and WAIT (one fetch outstanding); at most one fetch is outstanding at any time.
REQ-019 SHALL drive try_start_insfetch_task = (state==IDLE) && (count<QUEUE_DEPTH) && !flush_pipline, combinationally; insfetch_addr = pc at all times.
REQ-020 In IDLE with rdy_in=1 and the request asserted, SHALL move to WAIT at the clock edge; the request SHALL be low throughout WAIT.
REQ-021 In WAIT with rdy_in=1 and insfetch_task_done=1, SHALL perform all of the following at that edge and return to IDLE: push {insfetch_ins_full, pc, compressed} to the queue tail; advance pc.
REQ-022 compressed SHALL equal (insfetch_ins_full[1:0] != 2'b11).
REQ-023 pc SHALL advance by 2 when compressed, else by 4; arithmetic is modulo 2^32, so 32'hFFFFFFFC + 4 wraps to 0.
REQ-024 Minimum fetch-to-fetch spacing SHALL be one IDLE cycle after each done.
REQ-025 ins_out_valid SHALL equal (count != 0); ins_out_ins, ins_out_pc and ins_out_is_compressed SHALL reflect the queue head combinationally.
REQ-026 A pop SHALL occur when ins_out_valid && ins_out_ready && rdy_in.
REQ-027 Push and pop in the same cycle SHALL leave count unchanged, including when count==1.
REQ-028 Push SHALL never occur at count==QUEUE_DEPTH; this is guaranteed by REQ-019, since pops only decrease count.
REQ-029 Queue SHALL use head/tail pointers of log2(QUEUE_DEPTH) bits wrapping modulo QUEUE_DEPTH, plus a count register of log2(QUEUE_DEPTH)+1 bits.
REQ-030 flush_pipline=1 with rdy_in=1 SHALL, at that edge: set count, head and tail to 0; set state to IDLE; load pc <= flush_pc.
REQ-031 Flush SHALL take priority over a simultaneous done, push or pop; the done data is dropped.
REQ-032 First request after a flush SHALL assert the cycle following the flush, with insfetch_addr = flush_pc.
REQ-033 rdy_in=0 SHALL hold all registers unchanged and ignore done, ready and flush; outputs continue to reflect held state.
REQ-034 flush_pc[0] is don't-care and SHALL be stored as given.

Reset
REQ-035 On rst_in=1 at a clock edge, irrespective of rdy_in, SHALL set: state=IDLE; pc=RESET_PC; count=0; head=0; tail=0.
REQ-036 Reset SHALL take priority over flush and done; an in-flight fetch is abandoned.
REQ-037 Outputs during and one cycle after reset SHALL be: ins_out_valid=0; try_start_insfetch_task=0 during reset, 1 after release; insfetch_addr=RESET_PC.

Verification
REQ-038 Reset release, adapter model returns 32'h00500093 after 5 cycles -> request at pc 0; queue head {ins 32'h00500093, pc 0, compressed 0}; next request at addr 4.
REQ-039 Adapter returns 32'h00004505 at pc 4 -> head pc 4, is_compressed=1; next insfetch_addr=6.
REQ-040 ins_out_ready held 0 -> exactly 4 entries fetched; request stays low while count==4; one pop re-enables the request next cycle.
REQ-041 flush_pipline with flush_pc=32'h1000 in the same cycle as done -> done data dropped; ins_out_valid=0 next cycle; next request addr 32'h1000.
REQ-042 rdy_in=0 for 3 cycles while done and ready are high -> no push, no pop, pc unchanged; the capture happens on the first cycle rdy_in=1.
REQ-043 pc=32'hFFFFFFFC with a 32-bit instruction -> pc wraps to 0; push and pop at count=1 keep count=1.
